// File: rtl/ne16_evt_collector.sv
// Per-core event collector and job timer for the NE16 accelerator.
// Latency: event/ack affects pending_o/irq_o one edge later; job_done_o follows the busy fall by one edge.
// Backpressure: none; pulses are always accepted, and counters saturate with a sticky overflow flag.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous clear of all state (highest priority)
//   evt_i, ack_i        per (core,event) pulses, bit index c*N_EVT+e
//   busy_i              accelerator busy level
//   irq_o               per-core level interrupt (any pending counter non-zero)
//   pending_o           pending counters, slice [(c*N_EVT+e)*CNT_W +: CNT_W]
//   overflow_o          sticky counter saturation flags
//   job_cycles_o        cycle length of the last completed job
//   job_done_o          one-cycle strobe when job_cycles_o updates
module ne16_evt_collector #(
    parameter int N_CORES = 8,
    parameter int N_EVT   = 2,
    parameter int CNT_W   = 4,
    parameter int CYC_W   = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic [N_CORES*N_EVT-1:0]         evt_i,
    input  logic                             busy_i,
    input  logic [N_CORES*N_EVT-1:0]         ack_i,
    output logic [N_CORES-1:0]               irq_o,
    output logic [N_CORES*N_EVT*CNT_W-1:0]   pending_o,
    output logic [N_CORES*N_EVT-1:0]         overflow_o,
    output logic [CYC_W-1:0]                 job_cycles_o,
    output logic                             job_done_o
);

    localparam int                N_CNT   = N_CORES * N_EVT;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [CYC_W-1:0]  CYC_MAX = '1;
    localparam logic [CYC_W-1:0]  CYC_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ---------------- pending counters ----------------
    logic [CNT_W-1:0] cnt_q [N_CNT];
    logic [CNT_W-1:0] cnt_d [N_CNT];
    logic [N_CNT-1:0] ovf_q;
    logic [N_CNT-1:0] ovf_d;

    // Simultaneous evt+ack cancel out, so only the lone cases move a counter.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < N_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (evt_i[i] && !ack_i[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (!evt_i[i] && ack_i[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
            ovf_q <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < N_CNT; i++) cnt_q[i] <= cnt_d[i];
            ovf_q <= ovf_d;
        end
    end

    // Interrupt is decoded straight from the counters so it tracks them with no extra delay.
    always_comb begin
        irq_o = '0;
        for (int c = 0; c < N_CORES; c++) begin
            for (int e = 0; e < N_EVT; e++) begin
                if (cnt_q[c*N_EVT+e] != '0) irq_o[c] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CNT; g++) begin : g_pend
        assign pending_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign overflow_o = ovf_q;

    // ---------------- job timer ----------------
    state_t           state_q;
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] job_cycles_q;
    logic             job_done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            job_cycles_q <= '0;
            job_done_q   <= 1'b0;
        end else if (clear_i) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            job_cycles_q <= '0;
            job_done_q   <= 1'b0;
        end else begin
            job_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (busy_i) begin
                        state_q <= RUN;
                        cyc_q   <= CYC_ONE;
                    end
                end
                RUN: begin
                    if (busy_i) begin
                        if (cyc_q != CYC_MAX) cyc_q <= cyc_q + CYC_ONE;
                    end else begin
                        state_q      <= DONE;
                        job_cycles_q <= cyc_q;
                        job_done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    // A job may start on the very cycle the previous one is reported.
                    if (busy_i) begin
                        state_q <= RUN;
                        cyc_q   <= CYC_ONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign job_cycles_o = job_cycles_q;
    assign job_done_o   = job_done_q;

endmodule

// File: tb/tb_ne16_evt_collector.sv
// Self-checking bench for ne16_evt_collector: directed vector table, job/reset sequences, random run.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: none in the DUT; stimulus is applied freely every cycle.
module tb_ne16_evt_collector;

    localparam int NC = 8;
    localparam int NE = 2;
    localparam int CW = 4;
    localparam int YW = 32;
    localparam int NB = NC * NE;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic [NB-1:0]   evt;
    logic            busy;
    logic [NB-1:0]   ack;
    logic [NC-1:0]   irq;
    logic [NB*CW-1:0] pending;
    logic [NB-1:0]   overflow;
    logic [YW-1:0]   job_cycles;
    logic            job_done;

    int total = 0;
    int bad   = 0;

    ne16_evt_collector #(.N_CORES(NC), .N_EVT(NE), .CNT_W(CW), .CYC_W(YW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .evt_i        (evt),
        .busy_i       (busy),
        .ack_i        (ack),
        .irq_o        (irq),
        .pending_o    (pending),
        .overflow_o   (overflow),
        .job_cycles_o (job_cycles),
        .job_done_o   (job_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Counters follow the plain arithmetic rules; a job is a run of consecutive busy samples,
    // reported on the first low sample after the run.
    int      m_cnt [NB];
    bit      m_ovf [NB];
    int      m_run;
    bit      m_done;
    longint  m_cyc;

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_run  = 0;
        m_done = 1'b0;
        m_cyc  = 0;
    endfunction

    function automatic void model_update(input logic [NB-1:0] e, input logic [NB-1:0] a,
                                         input logic b, input logic c);
        if (c) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NB; i++) begin
            if (e[i] && !a[i]) begin
                if (m_cnt[i] == (1 << CW) - 1) m_ovf[i] = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end else if (!e[i] && a[i] && m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
            end
        end
        m_done = 1'b0;
        if (b) begin
            m_run = m_run + 1;
        end else if (m_run > 0) begin
            m_done = 1'b1;
            m_cyc  = m_run;
            m_run  = 0;
        end
    endfunction

    function automatic logic [NB*CW-1:0] model_pending();
        logic [NB*CW-1:0] p;
        p = '0;
        for (int i = 0; i < NB; i++) p[i*CW +: CW] = CW'(m_cnt[i]);
        return p;
    endfunction

    function automatic logic [NC-1:0] model_irq();
        logic [NC-1:0] q;
        q = '0;
        for (int i = 0; i < NB; i++) if (m_cnt[i] != 0) q[i/NE] = 1'b1;
        return q;
    endfunction

    function automatic logic [NB-1:0] model_ovf();
        logic [NB-1:0] o;
        for (int i = 0; i < NB; i++) o[i] = m_ovf[i];
        return o;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        check({tag, " pending"},  64'(pending),    64'(model_pending()));
        check({tag, " irq"},      64'(irq),        64'(model_irq()));
        check({tag, " overflow"}, 64'(overflow),   64'(model_ovf()));
        check({tag, " done"},     64'(job_done),   64'(m_done));
        check({tag, " cycles"},   64'(job_cycles), 64'(m_cyc));
    endtask

    task automatic step(input logic [NB-1:0] e, input logic [NB-1:0] a,
                        input logic b, input logic c, input string tag);
        evt   = e;
        ack   = a;
        busy  = b;
        clear = c;
        @(posedge clk);
        #1;
        model_update(e, a, b, c);
        cmp_model(tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NB-1:0] evt;
        logic [NB-1:0] ack;
        int            rep;
        int            idx;
        int            exp_cnt;
        logic [NC-1:0] exp_irq;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{16'h0020, 16'h0000,  1, 5, 1,  8'h04, 1'b0}; // evt (2,1)
        vecs[1] = '{16'h0000, 16'h0020,  1, 5, 0,  8'h00, 1'b0}; // ack (2,1)
        vecs[2] = '{16'h0001, 16'h0000, 17, 0, 15, 8'h01, 1'b1}; // saturate (0,0)
        vecs[3] = '{16'h0000, 16'h0001, 15, 0, 0,  8'h00, 1'b1}; // drain, overflow sticks
        vecs[4] = '{16'h0004, 16'h0000,  3, 2, 3,  8'h02, 1'b0}; // (1,0) to 3
        vecs[5] = '{16'h0004, 16'h0004,  1, 2, 3,  8'h02, 1'b0}; // evt+ack at 3
        vecs[6] = '{16'h0000, 16'h0004,  3, 2, 0,  8'h00, 1'b0}; // drain to 0
        vecs[7] = '{16'h0004, 16'h0004,  1, 2, 0,  8'h00, 1'b0}; // evt+ack at 0
        vecs[8] = '{16'h0000, 16'h0004,  1, 2, 0,  8'h00, 1'b0}; // lone ack at 0

        rst_n = 1'b0;
        clear = 1'b0;
        evt   = '0;
        ack   = '0;
        busy  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        cmp_model("reset");

        for (int v = 0; v < 9; v++) begin
            for (int r = 0; r < vecs[v].rep; r++) step(vecs[v].evt, vecs[v].ack, 1'b0, 1'b0, "table");
            check($sformatf("vec%0d cnt", v), 64'(pending[vecs[v].idx*CW +: CW]), 64'(vecs[v].exp_cnt));
            check($sformatf("vec%0d irq", v), 64'(irq), 64'(vecs[v].exp_irq));
            check($sformatf("vec%0d ovf", v), 64'(overflow[vecs[v].idx]), 64'(vecs[v].exp_ovf));
        end

        // Walking one: only the addressed slice and its core's interrupt move.
        for (int i = 0; i < NB; i++) begin
            logic [NB-1:0]    one;
            logic [NB*CW-1:0] exp_p;
            logic [NC-1:0]    exp_i;
            one   = NB'(1) << i;
            exp_p = (NB*CW)'(1) << (i*CW);
            exp_i = NC'(1) << (i/NE);
            step(one, '0, 1'b0, 1'b0, "walk");
            check($sformatf("walk%0d pending", i), 64'(pending), 64'(exp_p));
            check($sformatf("walk%0d irq", i), 64'(irq), 64'(exp_i));
            step('0, one, 1'b0, 1'b0, "walk_ack");
            check($sformatf("walk%0d cleared", i), 64'(pending), 64'h0);
        end

        // 100-cycle job followed by a 5-cycle job started on the DONE cycle.
        repeat (100) step('0, '0, 1'b1, 1'b0, "job100");
        step('0, '0, 1'b0, 1'b0, "job100_fall");
        check("job100 done", 64'(job_done), 64'h1);
        check("job100 cycles", 64'(job_cycles), 64'd100);
        step('0, '0, 1'b1, 1'b0, "job5");
        check("job100 single strobe", 64'(job_done), 64'h0);
        repeat (4) step('0, '0, 1'b1, 1'b0, "job5");
        step('0, '0, 1'b0, 1'b0, "job5_fall");
        check("job5 done", 64'(job_done), 64'h1);
        check("job5 cycles", 64'(job_cycles), 64'd5);
        step('0, '0, 1'b0, 1'b0, "idle");
        check("job5 cycles hold", 64'(job_cycles), 64'd5);

        // Asynchronous reset in the middle of a job with counters non-zero.
        step(16'h0208, '0, 1'b1, 1'b0, "pre_rst");
        repeat (19) step('0, '0, 1'b1, 1'b0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst pending", 64'(pending), 64'h0);
        check("arst irq", 64'(irq), 64'h0);
        check("arst cycles", 64'(job_cycles), 64'h0);
        check("arst done", 64'(job_done), 64'h0);
        #2;
        rst_n = 1'b1;
        repeat (30) step('0, '0, 1'b1, 1'b0, "post_rst");
        step('0, '0, 1'b0, 1'b0, "post_rst_fall");
        check("arst job cycles", 64'(job_cycles), 64'd30);
        check("arst job done", 64'(job_done), 64'h1);

        // Synchronous clear mid-job; it also overrides events on the same edge.
        step(16'h8010, '0, 1'b1, 1'b0, "pre_clr");
        repeat (19) step('0, '0, 1'b1, 1'b0, "pre_clr");
        step(16'hffff, '0, 1'b1, 1'b1, "clr");
        check("clr pending", 64'(pending), 64'h0);
        check("clr irq", 64'(irq), 64'h0);
        check("clr cycles", 64'(job_cycles), 64'h0);
        check("clr done", 64'(job_done), 64'h0);
        repeat (30) step('0, '0, 1'b1, 1'b0, "post_clr");
        step('0, '0, 1'b0, 1'b0, "post_clr_fall");
        check("clr job cycles", 64'(job_cycles), 64'd30);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [NB-1:0] re;
            logic [NB-1:0] ra;
            logic          rc;
            re = NB'($urandom & $urandom);
            ra = NB'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) busy = ~busy;
            rc = ($urandom_range(0, 299) == 0);
            step(re, ra, busy, rc, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ne16_evt_collector.md
Name: ne16_evt_collector

Overview:
- Sits directly downstream of the NE16 accelerator top level; consumes its per-core event pulse vector and its busy level.
- Converts single-cycle event pulses into per-core pending-event counters and level interrupts; cores acknowledge pending events one at a time.
- Measures the cycle length of each job from the busy level and publishes it with a one-cycle done strobe, for cluster event-unit and performance-counter use.

Parameters:
- N_CORES, 8, number of cores receiving events (matches the accelerator's core count).
- N_EVT, 2, events per core (matches the register-file event count).
- CNT_W, 4, width of each pending-event counter; saturates at 2^CNT_W-1.
- CYC_W, 32, width of the job cycle counter; saturates at all-ones.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear of all state.
- evt_i  in  N_CORES*N_EVT  event pulses; bit index c*N_EVT+e.
- busy_i  in  1  accelerator busy level.
- ack_i  in  N_CORES*N_EVT  acknowledge pulses, same indexing as evt_i.
- irq_o  out  N_CORES  per-core interrupt level.
- pending_o  out  N_CORES*N_EVT*CNT_W  pending counters; slice [(c*N_EVT+e)*CNT_W +: CNT_W].
- overflow_o  out  N_CORES*N_EVT  sticky saturation flags.
- job_cycles_o  out  CYC_W  cycle count of the last completed job.
- job_done_o  out  1  one-cycle strobe; job_cycles_o is valid from this cycle onward.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset values: every counter, every flag, job_cycles_o, job_done_o and irq_o are 0; the FSM is in IDLE.
- clear_i has priority over all other inputs. It gives the same state as reset on the next edge.
- Pending counter (c,e), updated each edge:
  - evt=1, ack=0: cnt+1. If cnt is already max, cnt holds and overflow(c,e) is set. overflow stays set until reset or clear.
  - evt=0, ack=1: cnt-1. If cnt is 0, cnt holds and the ack is ignored; no error is flagged.
  - evt=1, ack=1: cnt is unchanged, including at max and at 0.
  - All (c,e) pairs update independently and in parallel.
- irq_o[c] is the OR over e of (cnt(c,e)!=0), decoded from registers with no extra register stage.
  - An event pulse in cycle t gives irq high in cycle t+1.
  - An ack that empties the last counter in cycle t gives irq low in cycle t+1.
- Job timer FSM, states IDLE, RUN, DONE:
  - IDLE: if busy_i=1, go to RUN with cyc=1. Otherwise stay.
  - RUN, busy_i=1: cyc=cyc+1, saturating at 2^CYC_W-1.
  - RUN, busy_i=0: job_cycles_o<=cyc, go to DONE.
  - DONE: job_done_o=1 for exactly this cycle. If busy_i=1, go to RUN with cyc=1 (back-to-back jobs); otherwise go to IDLE.
  - job_done_o is 0 in IDLE and RUN. job_cycles_o holds until the next DONE or a clear.
- Reported count: cyc equals the number of cycles busy_i was sampled high. A busy pulse one cycle long reports 1.
- Reset or clear mid-job: FSM returns to IDLE with no job_done_o. If busy_i is still high, counting restarts at 1 on the next edge, so the job reports a shortened count.

Test Plan:
- Reset, then one evt_i[c=2,e=1] pulse → pending(2,1)=1 and irq_o=0x04 in the next cycle. Then ack_i[2,1] → pending=0 and irq_o=0x00 one cycle later.
- 17 consecutive evt_i[0,0] pulses with CNT_W=4 → pending(0,0)=15 and overflow_o[0]=1. Then 15 acks → pending=0, overflow still 1, irq_o[0]=0.
- Simultaneous evt and ack on (1,0) with pending=3 → stays 3. Simultaneous evt and ack with pending=0 → stays 0, irq_o[1]=0. Lone ack at 0 → stays 0, no overflow.
- busy_i high for 100 cycles, then low → job_done_o pulses once, 1 cycle after the fall, with job_cycles_o=100. A second job of 5 cycles starts on the DONE cycle → next strobe reports 5.
- Assert rst_ni low asynchronously, and separately clear_i for one cycle, in the middle of a 50-cycle job with pending counters non-zero → all outputs 0 immediately for reset and next edge for clear, with no job_done_o. Busy still high afterwards → the job reports the remaining cycle count only.
- Walking-one evt_i across all N_CORES*N_EVT bits → only the matching pending slice increments and only the matching irq_o bit rises.
